ex_branch_unit_pipe: RTL and testbench
======================================

Name: ex_branch_unit_pipe

Overview:
Parametrised, registered successor to the combinational EX branch-resolution logic in the SimpleRISC core.
- Holds the E/GT flags register, which is updated by cmp instructions.
- Keeps an optional return-address stack (RAS) for call/ret.
- Resolves the branch outcome and next PC one cycle after acceptance, with valid/ready handshakes on both sides.
- Sits between the ID/EX pipeline register and the fetch-redirect logic.

Parameters:
ADDR_W, 32, width of PC, branch target and op1.
RAS_DEPTH, 8, RAS entries (power of two, >=2).
USE_RAS, 1, 1: ret target is popped from the RAS; 0: ret target is op1 (legacy behaviour).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction presented
in_ready  out  1  unit can accept this cycle
pc  in  ADDR_W  PC of presented instruction
branchTarget  in  ADDR_W  immediate branch/call target
op1  in  ADDR_W  register operand (ra value for legacy ret)
isRet, isBeq, isBgt, isUBranch, isCall, isCmp  in  1 each  decoded control
cmp_flags  in  2  compare result from ALU, [1]=E, [0]=GT
clr_err  in  1  clears sticky error flags
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
isBranchTaken  out  1  redirect required
branchPC  out  ADDR_W  next PC (target if taken, pc+4 otherwise)
flags  out  2  current flags register
ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries
ras_overflow, ras_underflow  out  1 each  sticky error flags

Behaviour:
- Reset: out_valid=0, isBranchTaken=0, branchPC=0, flags=00, ras_count=0, both sticky flags=0. A held result is dropped; no RAS/flags update on the reset cycle.
- in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
- Latency: result registered on the accept edge, out_valid=1 next cycle.
  - Result held stable while out_valid & !out_ready.
  - out_valid falls after out_ready with no new accept.
  - Back-to-back accepts give one result per cycle.
- Flags: on accept with isCmp=1, flags <= cmp_flags.
  - A branch in the same instruction uses the old flags.
  - The next accepted instruction sees the new flags.
- Taken = isRet | isUBranch | isCall | (isBeq & flags[1]) | (isBgt & flags[0]).
- branchPC priority:
  1. isRet: the ret target.
  2. isUBranch or isCall: branchTarget.
  3. Conditional branch taken: branchTarget.
  4. Otherwise: pc+4, computed mod 2^ADDR_W (0xFFFFFFFC wraps to 0).
- Ret target:
  - USE_RAS=1: top of RAS, popped on accept.
  - USE_RAS=1 and RAS empty: use op1, set ras_underflow, count stays 0.
  - USE_RAS=0: op1; the RAS is never touched and ras_count stays 0.
- Call (USE_RAS=1): push pc+4 on accept. When full, overwrite the oldest entry (circular), keep count=RAS_DEPTH, set ras_overflow.
- isCall & isRet together: target from the ret rule; the top entry is replaced by pc+4 and count is unchanged. If the RAS is empty, it is a push only (count becomes 1) and underflow is set.
- Sticky flags clear on clr_err. A same-cycle set wins over the clear.
- No control asserted: taken=0, branchPC=pc+4.

Decomposition:
- Shared package simple_risc_pkg:
  - FLAG_E=1, FLAG_GT=0.
  - INSTR_BYTES=4.
  - A typedef for the 2-bit flags.
- One sub-module, ras_stack: circular buffer with push/pop/replace and count, full/empty outputs. ex_branch_unit_pipe instantiates it only when USE_RAS=1 (generate).

Test Plan:
1. Reset, then flags=00; beq with pc=0x100, branchTarget=0x3000 -> taken=0, branchPC=0x104.
2. Accept cmp with cmp_flags=10, then beq with branchTarget=0x3000 -> flags=10, taken=1, branchPC=0x3000. A bgt with flags=10 -> taken=0.
3. call at pc=0x200, then ret with op1=0xDEAD -> ras_count goes 1 then 0; ret branchPC=0x204, taken=1. With USE_RAS=0 the same ret gives branchPC=0xDEAD.
4. RAS_DEPTH=8: nine calls at pc=0x10,0x20,...,0x90, then nine rets -> ras_overflow=1, count=8. Rets return 0x94..0x24 in order; the ninth ret gives op1 and sets ras_underflow=1.
5. Hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, result stable, no flags/RAS change. Release -> one result per cycle with no loss.
6. Assert rst while out_valid=1 with ras_count=3 -> next cycle out_valid=0, branchPC=0, flags=00, ras_count=0. Also check a call at pc=0xFFFFFFFC pushes 0x00000000.

Source files
------------

// File: rtl/simple_risc_pkg.sv
// Shared SimpleRISC definitions: flag bit positions, instruction size and the flags type.
package simple_risc_pkg;
    localparam int FLAG_E      = 1;
    localparam int FLAG_GT     = 0;
    localparam int INSTR_BYTES = 4;

    typedef logic [1:0] flags_t;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with push, pop and replace-top.
// A push when full overwrites the oldest entry and leaves the count saturated.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   replace,
    input  logic [W-1:0]           pushData,
    output logic [W-1:0]           top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] topPtr;
    logic [PW-1:0] nextPtr;
    logic [PW-1:0] prevPtr;

    assign nextPtr = topPtr + 1'b1;
    assign prevPtr = topPtr - 1'b1;
    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign top     = mem[topPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            topPtr <= '0;
            count  <= '0;
        end else if (push) begin
            topPtr <= nextPtr;
            if (!full) count <= count + 1'b1;
        end else if (pop && !empty) begin
            topPtr <= prevPtr;
            count  <= count - 1'b1;
        end
    end

    // Storage has no reset; count/topPtr define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push)         mem[nextPtr] <= pushData;
            else if (replace) mem[topPtr]  <= pushData;
        end
    end
endmodule

// File: rtl/ex_branch_unit_pipe.sv
// Registered EX-stage branch resolution: flags register, optional RAS, next-PC result.
// Handshake: a transfer happens on a rising edge where valid & ready; in_ready = !out_valid | out_ready.
module ex_branch_unit_pipe
    import simple_risc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8,
    parameter bit USE_RAS   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            pc,
    input  logic [ADDR_W-1:0]            branchTarget,
    input  logic [ADDR_W-1:0]            op1,
    input  logic                         isRet,
    input  logic                         isBeq,
    input  logic                         isBgt,
    input  logic                         isUBranch,
    input  logic                         isCall,
    input  logic                         isCmp,
    input  logic [1:0]                   cmp_flags,
    input  logic                         clr_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         isBranchTaken,
    output logic [ADDR_W-1:0]            branchPC,
    output flags_t                       flags,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);
    logic              accept;
    logic [ADDR_W-1:0] seqPC;
    logic              condTaken;
    logic              takenNext;
    logic [ADDR_W-1:0] retTarget;
    logic [ADDR_W-1:0] nextPC;
    logic              setOvf;
    logic              setUnf;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign seqPC     = pc + ADDR_W'(INSTR_BYTES);
    // Conditional branches see the flags from before this instruction's own cmp.
    assign condTaken = (isBeq && flags[FLAG_E]) || (isBgt && flags[FLAG_GT]);
    assign takenNext = isRet || isUBranch || isCall || condTaken;

    generate
        if (USE_RAS) begin : g_ras
            logic              rasFull;
            logic              rasEmpty;
            logic [ADDR_W-1:0] rasTop;
            logic              doPush;
            logic              doPop;
            logic              doReplace;

            // call+ret swaps the top for the new return address; on an empty stack it is a plain push.
            assign doReplace = accept && isCall && isRet && !rasEmpty;
            assign doPush    = accept && isCall && !(isRet && !rasEmpty);
            assign doPop     = accept && isRet && !isCall;

            ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
                .clk      (clk),
                .rst      (rst),
                .push     (doPush),
                .pop      (doPop),
                .replace  (doReplace),
                .pushData (seqPC),
                .top      (rasTop),
                .count    (ras_count),
                .full     (rasFull),
                .empty    (rasEmpty)
            );

            assign retTarget = rasEmpty ? op1 : rasTop;
            assign setOvf    = doPush && rasFull;
            assign setUnf    = accept && isRet && rasEmpty;
        end else begin : g_noRas
            assign ras_count = '0;
            assign retTarget = op1;
            assign setOvf    = 1'b0;
            assign setUnf    = 1'b0;
        end
    endgenerate

    always_comb begin
        nextPC = seqPC;
        if (isRet)                                nextPC = retTarget;
        else if (isUBranch || isCall || condTaken) nextPC = branchTarget;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            isBranchTaken <= 1'b0;
            branchPC      <= '0;
            flags         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (accept) begin
                out_valid     <= 1'b1;
                isBranchTaken <= takenNext;
                branchPC      <= nextPC;
                if (isCmp) flags <= cmp_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A new error in the same cycle beats the clear.
            if (setOvf)       ras_overflow  <= 1'b1;
            else if (clr_err) ras_overflow  <= 1'b0;
            if (setUnf)       ras_underflow <= 1'b1;
            else if (clr_err) ras_underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_branch_unit_pipe.sv
// Bench for ex_branch_unit_pipe: directed vector table, multi-cycle sequences, random vs. queue model.
// Two instances share stimulus: one with the RAS, one with legacy op1 returns.
module tb_ex_branch_unit_pipe;
  localparam int AW = 32;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 1 + AW + AW + 2 + CW + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, out_ready, clr_err;
  logic [AW-1:0] pc, branch_target, op1;
  logic is_ret, is_beq, is_bgt, is_ubranch, is_call, is_cmp;
  logic [1:0] cmp_flags;

  logic in_ready, out_valid, taken, ovf, unf;
  logic [AW-1:0] branch_pc;
  logic [1:0] flags;
  logic [CW-1:0] ras_count;
  logic in_ready0, out_valid0, taken0, ovf0, unf0;
  logic [AW-1:0] branch_pc0;
  logic [1:0] flags0;
  logic [CW-1:0] ras_count0;

  ex_branch_unit_pipe #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .USE_RAS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
    .branchTarget(branch_target), .op1(op1), .isRet(is_ret), .isBeq(is_beq),
    .isBgt(is_bgt), .isUBranch(is_ubranch), .isCall(is_call), .isCmp(is_cmp),
    .cmp_flags(cmp_flags), .clr_err(clr_err), .out_valid(out_valid),
    .out_ready(out_ready), .isBranchTaken(taken), .branchPC(branch_pc),
    .flags(flags), .ras_count(ras_count), .ras_overflow(ovf), .ras_underflow(unf)
  );

  ex_branch_unit_pipe #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .USE_RAS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .pc(pc),
    .branchTarget(branch_target), .op1(op1), .isRet(is_ret), .isBeq(is_beq),
    .isBgt(is_bgt), .isUBranch(is_ubranch), .isCall(is_call), .isCmp(is_cmp),
    .cmp_flags(cmp_flags), .clr_err(clr_err), .out_valid(out_valid0),
    .out_ready(out_ready), .isBranchTaken(taken0), .branchPC(branch_pc0),
    .flags(flags0), .ras_count(ras_count0), .ras_overflow(ovf0), .ras_underflow(unf0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic cmp; logic [1:0] cf;
    logic beq, bgt, ub, call, ret;
    logic [AW-1:0] pc, tgt, op1;
    logic e_taken;
    logic [AW-1:0] e_pc, e_pc0;
    logic [1:0] e_flags;
    int e_cnt;
    logic e_ovf, e_unf;
  } vec_t;

  function automatic vec_t mk(input logic cmp, input logic [1:0] cf, input logic beq, bgt, ub, call, ret,
                              input logic [AW-1:0] p, tgt, o1, input logic et,
                              input logic [AW-1:0] epc, epc0, input logic [1:0] ef, input int ec,
                              input logic eo, eu);
    vec_t v;
    v.cmp = cmp; v.cf = cf; v.beq = beq; v.bgt = bgt; v.ub = ub; v.call = call; v.ret = ret;
    v.pc = p; v.tgt = tgt; v.op1 = o1; v.e_taken = et; v.e_pc = epc; v.e_pc0 = epc0;
    v.e_flags = ef; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    is_cmp = v.cmp; cmp_flags = v.cf; is_beq = v.beq; is_bgt = v.bgt; is_ubranch = v.ub;
    is_call = v.call; is_ret = v.ret; pc = v.pc; branch_target = v.tgt; op1 = v.op1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; is_cmp = 0; cmp_flags = 0; is_beq = 0; is_bgt = 0; is_ubranch = 0;
    is_call = 0; is_ret = 0; pc = 0; branch_target = 0; op1 = 0;
  endtask

  task automatic do_reset();
    clear_inputs(); out_ready = 1; clr_err = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Issue one instruction with out_ready high, then check both instances.
  task automatic apply_vec(input string name, input vec_t v);
    drive(v); in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    clear_inputs();
    check({name, ".valid"}, 80'(out_valid), 80'(1));
    check({name, ".taken"}, 80'(taken), 80'(v.e_taken));
    check({name, ".pc"}, 80'(branch_pc), 80'(v.e_pc));
    check({name, ".pc_legacy"}, 80'(branch_pc0), 80'(v.e_pc0));
    check({name, ".flags"}, 80'(flags), 80'(v.e_flags));
    check({name, ".count"}, 80'(ras_count), 80'(v.e_cnt));
    check({name, ".sticky"}, 80'({ovf, unf}), 80'({v.e_ovf, v.e_unf}));
    check({name, ".legacy_ras"}, 80'({ras_count0, ovf0, unf0}), 80'(0));
  endtask

  vec_t vecs[16];

  // Behavioural model state for the random phase.
  logic [AW-1:0] ras_q[$];
  logic [1:0] m_flags;
  logic m_ovf, m_unf, m_valid;
  logic [EW-1:0] exp_q[$];

  task automatic model_accept();
    logic t;
    logic [AW-1:0] rt, ra, epc, epc0;
    t = is_ret | is_ubranch | is_call | (is_beq & m_flags[1]) | (is_bgt & m_flags[0]);
    rt = (ras_q.size() > 0) ? ras_q[$] : op1;
    ra = pc + 32'd4;
    epc = is_ret ? rt : (t ? branch_target : ra);
    epc0 = is_ret ? op1 : (t ? branch_target : ra);
    if (is_call && is_ret) begin
      if (ras_q.size() > 0) ras_q[ras_q.size() - 1] = ra;
      else begin ras_q.push_back(ra); m_unf = 1; end
    end else if (is_call) begin
      if (ras_q.size() == DEPTH) begin void'(ras_q.pop_front()); m_ovf = 1; end
      ras_q.push_back(ra);
    end else if (is_ret) begin
      if (ras_q.size() > 0) void'(ras_q.pop_back());
      else m_unf = 1;
    end
    if (is_cmp) m_flags = cmp_flags;
    exp_q.push_back({t, epc, epc0, m_flags, CW'(ras_q.size()), m_ovf, m_unf});
  endtask

  initial begin
    vecs[0]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 'h100, 'h3000, 0, 0, 'h104, 'h104, 2'b00, 0, 0, 0);
    vecs[1]  = mk(1, 2'b10, 0, 0, 0, 0, 0, 'h104, 0, 0, 0, 'h108, 'h108, 2'b10, 0, 0, 0);
    vecs[2]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 'h108, 'h3000, 0, 1, 'h3000, 'h3000, 2'b10, 0, 0, 0);
    vecs[3]  = mk(0, 2'b00, 0, 1, 0, 0, 0, 'h10C, 'h3000, 0, 0, 'h110, 'h110, 2'b10, 0, 0, 0);
    vecs[4]  = mk(0, 2'b00, 0, 0, 0, 1, 0, 'h200, 'h5000, 0, 1, 'h5000, 'h5000, 2'b10, 1, 0, 0);
    vecs[5]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 'h5000, 0, 'hDEAD, 1, 'h204, 'hDEAD, 2'b10, 0, 0, 0);
    vecs[6]  = mk(0, 2'b00, 0, 0, 1, 0, 0, 'h300, 'h400, 0, 1, 'h400, 'h400, 2'b10, 0, 0, 0);
    vecs[7]  = mk(1, 2'b01, 0, 1, 0, 0, 0, 'h400, 'h800, 0, 0, 'h404, 'h404, 2'b01, 0, 0, 0);
    vecs[8]  = mk(0, 2'b00, 0, 1, 0, 0, 0, 'h404, 'h800, 0, 1, 'h800, 'h800, 2'b01, 0, 0, 0);
    vecs[9]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 'hFFFFFFFC, 'h10, 0, 0, 'h0, 'h0, 2'b01, 0, 0, 0);
    vecs[10] = mk(0, 2'b00, 0, 0, 0, 1, 0, 'h600, 'h900, 0, 1, 'h900, 'h900, 2'b01, 1, 0, 0);
    vecs[11] = mk(0, 2'b00, 0, 0, 0, 1, 1, 'h700, 'hA00, 'hBEEF, 1, 'h604, 'hBEEF, 2'b01, 1, 0, 0);
    vecs[12] = mk(0, 2'b00, 0, 0, 0, 0, 1, 'hA00, 0, 'h1, 1, 'h704, 'h1, 2'b01, 0, 0, 0);
    vecs[13] = mk(0, 2'b00, 0, 0, 0, 1, 1, 'h800, 'hA00, 'h55, 1, 'h55, 'h55, 2'b01, 1, 0, 1);
    vecs[14] = mk(0, 2'b00, 0, 0, 0, 0, 1, 'hA00, 0, 'h66, 1, 'h804, 'h66, 2'b01, 0, 0, 1);
    vecs[15] = mk(0, 2'b00, 1, 0, 0, 0, 0, 'h20, 'h900, 0, 0, 'h24, 'h24, 2'b01, 0, 0, 1);

    // Reset state.
    do_reset();
    check("reset.outs", 80'({out_valid, taken, branch_pc, flags, ras_count, ovf, unf}), 80'(0));
    check("reset.in_ready", 80'(in_ready), 80'(1));

    foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Clear of sticky errors on an idle cycle.
    clr_err = 1;
    @(posedge clk); #1;
    clr_err = 0;
    check("clr.sticky", 80'({ovf, unf}), 80'(0));
    check("clr.valid_drop", 80'(out_valid), 80'(0));

    // Nine calls overflow an 8-deep stack, nine rets unwind it and underflow once.
    do_reset();
    for (int k = 1; k <= 9; k++)
      apply_vec($sformatf("call%0d", k),
                mk(0, 0, 0, 0, 0, 1, 0, 32'(16 * k), 'h1000, 0, 1, 'h1000, 'h1000, 0,
                   (k > 8) ? 8 : k, k == 9, 0));
    for (int i = 0; i < 9; i++)
      apply_vec($sformatf("ret%0d", i),
                mk(0, 0, 0, 0, 0, 0, 1, 'h1000, 0, 'hBEEF, 1,
                   (i < 8) ? 32'('h94 - 16 * i) : 32'hBEEF, 'hBEEF, 0,
                   (i < 8) ? 7 - i : 0, 1, i == 8));
    // Same-cycle underflow beats clr_err; overflow clears.
    clr_err = 1;
    apply_vec("clr_vs_set", mk(0, 0, 0, 0, 0, 0, 1, 'h40, 0, 'h77, 1, 'h77, 'h77, 0, 0, 0, 1));
    clr_err = 0;

    // Backpressure: result held, no state change, then one result per cycle.
    @(posedge clk); #1;
    check("bp.idle_drop", 80'(out_valid), 80'(0));
    out_ready = 0;
    drive(mk(0, 0, 0, 0, 0, 1, 0, 'hA00, 'hB00, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1;
    @(posedge clk); #1;
    check("bp.first", 80'({out_valid, branch_pc, ras_count}), 80'({1'b1, 32'hB00, 4'd1}));
    drive(mk(1, 2'b11, 0, 0, 0, 1, 0, 'hC00, 'hD00, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp.stall_ready%0d", c), 80'(in_ready), 80'(0));
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", c), 80'({out_valid, taken, branch_pc, flags, ras_count}),
            80'({1'b1, 1'b1, 32'hB00, 2'b00, 4'd1}));
    end
    out_ready = 1;
    #1;
    check("bp.release_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;
    check("bp.second", 80'({out_valid, branch_pc, flags, ras_count}), 80'({1'b1, 32'hD00, 2'b11, 4'd2}));
    drive(mk(0, 0, 0, 0, 1, 0, 0, 'hE00, 'hF00, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("bp.third", 80'({out_valid, branch_pc, flags, ras_count}), 80'({1'b1, 32'hF00, 2'b11, 4'd2}));
    clear_inputs();
    @(posedge clk); #1;
    check("bp.drain", 80'(out_valid), 80'(0));

    // Reset while holding a result with three live entries; a call on that cycle is ignored.
    apply_vec("pre_rst", mk(0, 0, 0, 0, 0, 1, 0, 'h40, 'h50, 0, 1, 'h50, 'h50, 2'b11, 3, 0, 1));
    drive(mk(0, 0, 0, 0, 0, 1, 0, 'h60, 'h70, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0; clear_inputs();
    check("rst.outs", 80'({out_valid, taken, branch_pc, flags, ras_count, ovf, unf}), 80'(0));

    // Return address wraps past the top of the address space.
    apply_vec("wrap.call", mk(0, 0, 0, 0, 0, 1, 0, 'hFFFFFFFC, 'h100, 0, 1, 'h100, 'h100, 0, 1, 0, 0));
    apply_vec("wrap.ret", mk(0, 0, 0, 0, 0, 0, 1, 'h100, 0, 'h7, 1, 'h0, 'h7, 0, 0, 0, 0));

    // Random traffic with random backpressure against the queue model.
    do_reset();
    m_flags = 0; m_ovf = 0; m_unf = 0; m_valid = 0;
    ras_q.delete(); exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      int kind;
      kind = $urandom_range(0, 7);
      clear_inputs();
      is_cmp = (kind == 1) || ($urandom_range(0, 3) == 0);
      is_beq = (kind == 2); is_bgt = (kind == 3); is_ubranch = (kind == 4);
      is_call = (kind == 5) || (kind == 7); is_ret = (kind == 6) || (kind == 7);
      cmp_flags = 2'($urandom_range(0, 3));
      pc = $urandom; branch_target = $urandom; op1 = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rnd.in_ready", 80'({in_ready, in_ready0}), 80'({2{!m_valid || out_ready}}));
      check("rnd.out_valid", 80'(out_valid), 80'(m_valid));
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd.underrun: got output expected none");
        end else begin
          check("rnd.result", 80'({taken, branch_pc, branch_pc0, flags, ras_count, ovf, unf}),
                80'(exp_q.pop_front()));
          check("rnd.legacy", 80'({flags0, ras_count0, ovf0, unf0}), 80'({m_flags, 6'd0}));
        end
      end
      if (in_valid && (!m_valid || out_ready)) model_accept();
      if (in_valid && (!m_valid || out_ready)) m_valid = 1;
      else if (out_ready) m_valid = 0;
      @(posedge clk); #1;
    end
    clear_inputs();
    out_ready = 1;
    @(negedge clk);
    if (m_valid && exp_q.size() > 0)
      check("rnd.last", 80'({taken, branch_pc, branch_pc0, flags, ras_count, ovf, unf}),
            80'(exp_q.pop_front()));
    check("rnd.queue_empty", 80'(exp_q.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
